// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit with a start/busy/done handshake.
// Each CALC cycle retires UNROLL bits. Operands are held as magnitudes,
// and the sign is applied in FIX. Special divides skip CALC.
module mdu_iterative #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned N  = XLEN / UNROLL;
  localparam int unsigned CW = $clog2(N);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d;     // product high half / partial remainder
  logic [XLEN-1:0]   lo_q, lo_d;     // multiplier, dividend->quotient, or special value
  logic [XLEN-1:0]   opnd_q, opnd_d; // multiplicand or divisor magnitude
  logic [2:0]        op_q, op_d;
  logic              negq_q, negq_d; // negate product / quotient
  logic              nega_q, nega_d; // negate remainder
  logic              spec_q, spec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag, spec_val;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic [XLEN:0]     step_t;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

  // Operand sign handling and special-case detection at capture.
  assign a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
  assign b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign a_neg    = a_signed && a[XLEN-1];
  assign b_neg    = b_signed && b[XLEN-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign div_zero = funct3[2] && (b == '0);
  assign div_ovf  = funct3[2] && !funct3[0] && (a == MIN_INT) && (b == '1);
  assign spec_val = div_zero ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : MIN_INT);

  // One CALC iteration: UNROLL shift-add or restoring-divide steps.
  always_comb begin
    step_hi = hi_q;
    step_lo = lo_q;
    step_t  = '0;
    for (int i = 0; i < int'(UNROLL); i++) begin
      if (op_q[2]) begin
        step_t  = {step_hi, step_lo[XLEN-1]};
        step_lo = {step_lo[XLEN-2:0], 1'b0};
        if (step_t >= {1'b0, opnd_q}) begin
          step_t     = step_t - {1'b0, opnd_q};
          step_lo[0] = 1'b1;
        end
        step_hi = step_t[XLEN-1:0];
      end else begin
        step_t  = step_lo[0] ? ({1'b0, step_hi} + {1'b0, opnd_q}) : {1'b0, step_hi};
        step_lo = {step_t[0], step_lo[XLEN-1:1]};
        step_hi = step_t[XLEN:1];
      end
    end
  end

  // Sign correction and result selection used in FIX.
  assign prod     = {hi_q, lo_q};
  assign prod_fix = negq_q ? -prod : prod;
  assign quo_fix  = negq_q ? -lo_q : lo_q;
  assign rem_fix  = nega_q ? -hi_q : hi_q;

  always_comb begin
    fix_val = rem_fix;
    if (spec_q) begin
      fix_val = lo_q;
    end else begin
      case (op_q)
        3'b000:                 fix_val = prod_fix[XLEN-1:0];
        3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
        3'b100, 3'b101:         fix_val = quo_fix;
        default:                fix_val = rem_fix;
      endcase
    end
  end

  // Next-state, datapath and output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    negq_d   = negq_q;
    nega_d   = nega_q;
    spec_d   = spec_q;
    result_d = result_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          op_d   = funct3;
          negq_d = a_neg ^ b_neg;
          nega_d = a_neg;
          hi_d   = '0;
          cnt_d  = '0;
          if (div_zero || div_ovf) begin
            spec_d  = 1'b1;
            lo_d    = spec_val;
            state_d = S_FIX;
          end else begin
            spec_d  = 1'b0;
            state_d = S_CALC;
            if (funct3[2]) begin
              lo_d   = a_mag;
              opnd_d = b_mag;
            end else begin
              lo_d   = b_mag;
              opnd_d = a_mag;
            end
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        hi_d = step_hi;
        lo_d = step_lo;
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIX: begin
        result_d = fix_val;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      negq_q   <= 1'b0;
      nega_q   <= 1'b0;
      spec_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      negq_q   <= negq_d;
      nega_q   <= nega_d;
      spec_q   <= spec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
